uart_host_ctrl: RTL

//  Sequences the full UART through its Write/Read strobe interface and shares its

---
 rtl/uart_host_ctrl_if.sv | 25 ++
 rtl/uart_host_ctrl.sv | 62 ++++++
 2 files changed

// File: rtl/uart_host_ctrl_if.sv
// uart_host_ctrl_if: requester, rx-consumer and UART strobe signals of uart_host_ctrl
interface uart_host_ctrl_if;
  logic req0_valid;
  logic [7:0] req0_data;
  logic req0_ready;
  logic req1_valid;
  logic [7:0] req1_data;
  logic req1_ready;
  logic rx_valid;
  logic [7:0] rx_data;
  logic [2:0] rx_err;
  logic rx_ready;
  logic uart_write;
  logic [1:0] uart_read;
  logic [15:0] uart_out;
  logic [7:0] uart_ds;
  modport master (
    input req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_ds,
    output req0_ready, req1_ready, rx_valid, rx_data, rx_err, uart_write, uart_read, uart_out
  );
  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_ds,
    input req0_ready, req1_ready, rx_valid, rx_data, rx_err, uart_write, uart_read, uart_out
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: polls UART status, fetches RX bytes and round-robins TX between two requesters
module uart_host_ctrl #(
  parameter int SETTLE_CYC = 2
) (
  input logic clk,
  input logic rst,
  uart_host_ctrl_if.master bus
);
  typedef enum logic [1:0] {SETTLE, POLL, RXRD, TXWR} state_t;
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic rr_ptr, gnt, rx_valid, g;
  logic [7:0] tx_byte, rx_data;
  logic [2:0] rx_err;
  assign g = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
  assign bus.uart_write = state == TXWR;
  assign bus.uart_read = state == POLL ? 2'b10 : state == RXRD ? 2'b01 : 2'b00;
  assign bus.uart_out = state == TXWR ? {8'h00, tx_byte} : 16'h0000;
  assign bus.req0_ready = state == TXWR && !gnt;
  assign bus.req1_ready = state == TXWR && gnt;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data = rx_data;
  assign bus.rx_err = rx_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SETTLE;
      cnt <= '0;
      rr_ptr <= 1'b0;
      gnt <= 1'b0;
      tx_byte <= 8'h00;
      rx_valid <= 1'b0;
      rx_data <= 8'h00;
      rx_err <= 3'b000;
    end else begin
      if (rx_valid && bus.rx_ready) rx_valid <= 1'b0;
      case (state)
        SETTLE: begin
          cnt <= cnt == CW'(SETTLE_CYC - 1) ? '0 : cnt + CW'(1);
          if (cnt == CW'(SETTLE_CYC - 1)) state <= POLL;
        end
        POLL:
          // rx_err is only observable with rx_valid, which is low whenever a fetch starts
          if (bus.uart_ds[0] && !rx_valid) begin
            rx_err <= bus.uart_ds[4:2];
            state <= RXRD;
          end else if (bus.uart_ds[1] && (bus.req0_valid || bus.req1_valid)) begin
            gnt <= g;
            rr_ptr <= ~g;
            tx_byte <= g ? bus.req1_data : bus.req0_data;
            state <= TXWR;
          end
        RXRD: begin
          rx_data <= bus.uart_ds;
          rx_valid <= 1'b1;
          state <= SETTLE;
        end
        TXWR: state <= SETTLE;
      endcase
    end
  end
endmodule
